// File: rtl/bk_pkg.sv
// Shared types and constants for the bkProcessor command feeder.
package bk_pkg;

    localparam int CMD_W  = 7;
    localparam int DATA_W = 8;

    localparam logic [CMD_W-1:0] NOP_DEFAULT = 7'h00;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] d3;
    } bk_cmd_t;

    typedef enum logic {
        IDLE,
        HOLD
    } feeder_state_t;

endpackage

// File: rtl/bk_cmd_fifo.sv
// Synchronous FIFO of command packets; full/empty come from the occupancy count.
module bk_cmd_fifo
    import bk_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  bk_cmd_t       din,
    input  logic          pop,
    input  logic          flush,
    output bk_cmd_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    bk_cmd_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // A full FIFO refuses pushes even when a pop frees a slot this cycle
    assign push_ok = rst && push && !full && !flush;
    assign pop_ok  = rst && pop && !empty && !flush;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/bk_cmd_feeder.sv
// Queues command packets and issues each to bkProcessor for a fixed hold time.
module bk_cmd_feeder
    import bk_pkg::*;
#(
    parameter int               DEPTH     = 4,
    parameter int               ISSUE_GAP = 4,
    parameter logic [CMD_W-1:0] NOP_CMD   = NOP_DEFAULT,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int GW = $clog2(ISSUE_GAP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  in_cmd,
    input  logic [DATA_W-1:0] in_d1,
    input  logic [DATA_W-1:0] in_d2,
    input  logic [DATA_W-1:0] in_d3,
    input  logic              halt,
    input  logic              flush,
    output logic [CMD_W-1:0]  cmdin,
    output logic [DATA_W-1:0] din_1,
    output logic [DATA_W-1:0] din_2,
    output logic [DATA_W-1:0] din_3,
    output logic              issue_pulse,
    output logic              busy,
    output logic [LW-1:0]     level
);

    feeder_state_t state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    bk_cmd_t       out_q, out_d;
    logic          pulse_q, pulse_d;
    logic          pop;
    logic          full;
    logic          empty;
    bk_cmd_t       in_pkt;
    bk_cmd_t       head;
    bk_cmd_t       nop_pkt;

    assign in_pkt  = '{cmd: in_cmd, d1: in_d1, d2: in_d2, d3: in_d3};
    assign nop_pkt = '{cmd: NOP_CMD, d1: '0, d2: '0, d3: '0};
    assign in_ready = rst && !full;

    bk_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .din   (in_pkt),
        .pop   (pop),
        .flush (flush),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (level)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        out_d   = out_q;
        pulse_d = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                out_d = nop_pkt;
                if (!empty && !halt) begin
                    pop     = 1'b1;
                    out_d   = head;
                    pulse_d = 1'b1;
                    gap_d   = GW'(ISSUE_GAP - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (!empty && !halt) begin
                    pop     = 1'b1;
                    out_d   = head;
                    pulse_d = 1'b1;
                    gap_d   = GW'(ISSUE_GAP - 1);
                end else begin
                    out_d   = nop_pkt;
                    state_d = IDLE;
                end
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            gap_d   = '0;
            out_d   = nop_pkt;
            pulse_d = 1'b0;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            out_q   <= '{cmd: NOP_CMD, d1: '0, d2: '0, d3: '0};
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            pulse_q <= pulse_d;
        end
    end

    assign cmdin       = out_q.cmd;
    assign din_1       = out_q.d1;
    assign din_2       = out_q.d2;
    assign din_3       = out_q.d3;
    assign issue_pulse = pulse_q;
    assign busy        = (state_q == HOLD) || (level != '0);

endmodule

// File: tb/tb_bk_cmd_feeder.sv
// Self-checking bench for bk_cmd_feeder against a queue-based reference model.
module tb_bk_cmd_feeder;
    import bk_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT0: default gap
    logic v0, h0, f0, rdy0, pul0, busy0;
    bk_cmd_t p0;
    logic [6:0] cmd0;
    logic [7:0] a0, b0, c0;
    logic [2:0] lvl0;

    // DUT1: gap of one
    logic v1, rdy1, pul1, busy1;
    bk_cmd_t p1;
    logic [6:0] cmd1;
    logic [7:0] a1, b1, c1;
    logic [2:0] lvl1;

    bk_cmd_feeder #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .in_cmd(p0.cmd), .in_d1(p0.d1), .in_d2(p0.d2), .in_d3(p0.d3),
        .halt(h0), .flush(f0), .cmdin(cmd0), .din_1(a0), .din_2(b0),
        .din_3(c0), .issue_pulse(pul0), .busy(busy0), .level(lvl0)
    );

    bk_cmd_feeder #(.DEPTH(DEPTH), .ISSUE_GAP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_cmd(p1.cmd), .in_d1(p1.d1), .in_d2(p1.d2), .in_d3(p1.d3),
        .halt(1'b0), .flush(1'b0), .cmdin(cmd1), .din_1(a1), .din_2(b1),
        .din_3(c1), .issue_pulse(pul1), .busy(busy1), .level(lvl1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model for DUT0: queue of waiting packets plus remaining hold cycles
    bk_cmd_t mq[$];
    bk_cmd_t cur;
    int      hold;
    bit      mpulse;
    bit      macc;
    bit      acc1;
    bk_cmd_t sb1[$];

    function automatic bk_cmd_t rnd_pkt();
        bk_cmd_t p;
        p.cmd = 7'($urandom);
        p.d1  = 8'($urandom);
        p.d2  = 8'($urandom);
        p.d3  = 8'($urandom);
        return p;
    endfunction

    task automatic model_step();
        mpulse = 1'b0;
        macc   = 1'b0;
        if (!rst || f0) begin
            mq.delete();
            hold = 0;
            cur  = '0;
        end else begin
            macc = v0 && (mq.size() < DEPTH);
            if (hold <= 1) begin
                if (mq.size() > 0 && !h0) begin
                    cur    = mq.pop_front();
                    hold   = GAP;
                    mpulse = 1'b1;
                end else begin
                    hold = 0;
                    cur  = '0;
                end
            end else begin
                hold--;
            end
            if (macc) mq.push_back(p0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc1 = rst && v1 && rdy1;
        @(posedge clk);
        model_step();
        if (acc1) sb1.push_back(p1);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; v0 = 1'b1; h0 = 1'b0; f0 = 1'b0; v1 = 1'b0;
        p0 = rnd_pkt(); p1 = '0;
        tick();
        tick();
        n_tests++;
        if (cmd0 !== 7'h00 || a0 !== 8'h00 || b0 !== 8'h00 || c0 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h %h %h %h want 00 00 00 00", cmd0, a0, b0, c0);
        end
        n_tests++;
        if (lvl0 !== 3'd0 || busy0 !== 1'b0 || rdy0 !== 1'b0 || pul0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got level=%0d busy=%b ready=%b pulse=%b want 0 0 0 0",
                     lvl0, busy0, rdy0, pul0);
        end
        rst = 1'b1; v0 = 1'b0;
        #1;
        n_tests++;
        if (rdy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", rdy0);
        end
        tick();
        n_tests++;
        if (lvl0 !== 3'd0 || busy0 !== 1'b0 || cmd0 !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_empty: got level=%0d busy=%b cmd=%h want 0 0 00", lvl0, busy0, cmd0);
        end
    endtask

    task automatic test_single();
        p0 = '{cmd: 7'b0001110, d1: 8'h01, d2: 8'hA5, d3: 8'h3C};
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        n_tests++;
        if (lvl0 !== 3'd1 || cmd0 !== 7'h00 || pul0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_queued: got level=%0d cmd=%h pulse=%b want 1 00 0", lvl0, cmd0, pul0);
        end
        for (int i = 0; i < GAP; i++) begin
            tick();
            n_tests++;
            if ({cmd0, a0, b0, c0} !== {7'h0E, 8'h01, 8'hA5, 8'h3C} || pul0 !== (i == 0)) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got %h %h %h %h pulse=%b want 0e 01 a5 3c pulse=%b",
                         i, cmd0, a0, b0, c0, pul0, (i == 0));
            end
        end
        tick();
        n_tests++;
        if ({cmd0, a0, b0, c0} !== '0 || busy0 !== 1'b0 || pul0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got %h %h %h %h busy=%b want NOP/0 busy=0",
                     cmd0, a0, b0, c0, busy0);
        end
    endtask

    task automatic test_burst();
        bk_cmd_t pk[6];
        bk_cmd_t seen[$];
        int k = 0;
        int errs = 0;
        for (int i = 0; i < 6; i++) pk[i] = rnd_pkt();
        for (int c = 0; c < 60; c++) begin
            v0 = (k < 6);
            p0 = (k < 6) ? pk[k] : '0;
            tick();
            if (macc) k++;
            if (pul0) seen.push_back('{cmd: cmd0, d1: a0, d2: b0, d3: c0});
            if ({cmd0, a0, b0, c0} !== cur || pul0 !== mpulse || lvl0 !== 3'(mq.size())
                || rdy0 !== (mq.size() < DEPTH) || busy0 !== (hold > 0 || mq.size() > 0)) begin
                errs++;
                if (errs < 4)
                    $display("FAIL burst_cycle%0d: got cmd=%h pulse=%b level=%0d ready=%b want cmd=%h pulse=%b level=%0d",
                             c, cmd0, pul0, lvl0, rdy0, cur.cmd, mpulse, mq.size());
            end
        end
        v0 = 1'b0;
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL burst_model: got %0d bad cycles want 0", errs);
        end
        n_tests++;
        if (k != 6 || seen.size() != 6) begin
            n_fail++;
            $display("FAIL burst_count: got accepted=%0d issued=%0d want 6 6", k, seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (seen[i] !== pk[i]) begin
                    n_fail++;
                    $display("FAIL burst_order[%0d]: got %h want %h", i, seen[i], pk[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        bk_cmd_t pk[3];
        for (int i = 0; i < 3; i++) pk[i] = rnd_pkt();
        v0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p0 = pk[i];
            tick();
        end
        v0 = 1'b0;
        h0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if ({cmd0, a0, b0, c0} !== cur || lvl0 !== 3'(mq.size())) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %h level=%0d want %h level=%0d",
                         i, {cmd0, a0, b0, c0}, lvl0, cur, mq.size());
            end
        end
        n_tests++;
        if (cmd0 !== 7'h00 || lvl0 !== 3'd2) begin
            n_fail++;
            $display("FAIL halt_idle: got cmd=%h level=%0d want 00 2", cmd0, lvl0);
        end
        h0 = 1'b0;
        tick();
        n_tests++;
        if ({cmd0, a0, b0, c0} !== pk[1] || pul0 !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_resume: got %h pulse=%b want %h pulse=1", {cmd0, a0, b0, c0}, pul0, pk[1]);
        end
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (busy0 !== 1'b0 || cmd0 !== 7'h00) begin
            n_fail++;
            $display("FAIL halt_drain: got busy=%b cmd=%h want 0 00", busy0, cmd0);
        end
    endtask

    task automatic test_flush();
        v0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p0 = rnd_pkt();
            tick();
        end
        n_tests++;
        if (lvl0 !== 3'd3 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup: got level=%0d busy=%b want 3 1", lvl0, busy0);
        end
        f0 = 1'b1;
        p0 = rnd_pkt();
        tick();
        f0 = 1'b0;
        v0 = 1'b0;
        n_tests++;
        if ({cmd0, a0, b0, c0} !== '0 || lvl0 !== 3'd0 || busy0 !== 1'b0 || pul0 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_edge: got %h level=%0d busy=%b pulse=%b want 0 0 0 0",
                     {cmd0, a0, b0, c0}, lvl0, busy0, pul0);
        end
        tick();
        tick();
        n_tests++;
        if (lvl0 !== 3'd0 || busy0 !== 1'b0 || pul0 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dropped: got level=%0d busy=%b pulse=%b want 0 0 0", lvl0, busy0, pul0);
        end
    endtask

    task automatic test_wrap_gap1();
        bk_cmd_t pk[10];
        int k = 0;
        int npul = 0;
        int first = -1;
        int last = -1;
        int bad = 0;
        bk_cmd_t exp_p;
        for (int i = 0; i < 10; i++) begin
            pk[i] = rnd_pkt();
            pk[i].cmd[2:0] = ($urandom_range(0, 1) != 0) ? 3'b110 : 3'b101;
        end
        for (int c = 0; c < 40; c++) begin
            v1 = (k < 10);
            p1 = (k < 10) ? pk[k] : '0;
            tick();
            if (acc1) k++;
            if (v1 && rdy1 !== 1'b1) bad++;
            if (pul1) begin
                npul++;
                if (first < 0) first = cyc;
                last = cyc;
                exp_p = (sb1.size() > 0) ? sb1.pop_front() : '1;
                n_tests++;
                if ({cmd1, a1, b1, c1} !== exp_p) begin
                    n_fail++;
                    $display("FAIL wrap_order[%0d]: got %h want %h", npul - 1, {cmd1, a1, b1, c1}, exp_p);
                end
            end
        end
        v1 = 1'b0;
        n_tests++;
        if (k != 10 || npul != 10 || last - first != 9 || bad != 0) begin
            n_fail++;
            $display("FAIL wrap_rate: got accepted=%0d issued=%0d span=%0d stalls=%0d want 10 10 9 0",
                     k, npul, last - first, bad);
        end
        n_tests++;
        if (busy1 !== 1'b0 || lvl1 !== 3'd0 || cmd1 !== 7'h00) begin
            n_fail++;
            $display("FAIL wrap_idle: got busy=%b level=%0d cmd=%h want 0 0 00", busy1, lvl1, cmd1);
        end
    endtask

    initial begin
        hold = 0;
        cur  = '0;
        test_reset();
        test_single();
        test_burst();
        test_halt();
        test_flush();
        test_wrap_gap1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
